// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU codes, forward selects, branch funct3 values and E-stage control bundle
package riscv_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [3:0] alu_control;
    logic [2:0] funct3;
  } ctrl_t;
endpackage

// File: rtl/alu.sv
// alu: RV32I integer ALU; flags always reflect a - b so branches work under any opcode
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      ctrl_i,
  output logic [XLEN-1:0] result_o,
  output logic            z_o,
  output logic            n_o,
  output logic            c_o,
  output logic            v_o
);
  logic [XLEN:0]   sub_w;
  logic [XLEN-1:0] diff;
  logic [4:0]      shamt;
  assign sub_w = {1'b0, a_i} + {1'b0, ~b_i} + {{XLEN{1'b0}}, 1'b1};
  assign diff  = sub_w[XLEN-1:0];
  assign shamt = b_i[4:0];
  assign z_o = diff == '0;
  assign n_o = diff[XLEN-1];
  // carry set means no borrow, i.e. a >= b unsigned
  assign c_o = sub_w[XLEN];
  assign v_o = (a_i[XLEN-1] != b_i[XLEN-1]) && (diff[XLEN-1] != a_i[XLEN-1]);
  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = diff;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      default:  result_o = '0;
    endcase
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: ID/EX register with operand forwarding, ALU and branch/jump resolution
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [3:0]      ALUControlD,
  input  logic [2:0]      funct3D,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] ALUResultE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            PCSrcE,
  output logic [1:0]      ResultSrcE
);
  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    ctrl_t           ctrl;
  } e_t;
  e_t e_q, e_d, e_in;
  logic [XLEN-1:0] src_a, fwd_b, src_b;
  logic z, n, c, v, cond;
  assign e_in = '{rd1: RD1D, rd2: RD2D, pc: PCD, imm: ImmExtD, pc4: PCPlus4D,
                  rs1: Rs1D, rs2: Rs2D, rd: RdD,
                  ctrl: '{reg_write: RegWriteD, mem_write: MemWriteD, jump: JumpD,
                          branch: BranchD, alu_src: ALUSrcD, result_src: ResultSrcD,
                          alu_control: ALUControlD, funct3: funct3D}};
  assign e_d = FlushE ? '0 : StallE ? e_q : e_in;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) e_q <= '0;
    else e_q <= e_d;
  end
  assign src_a = ForwardAE == FWD_W ? ResultW : ForwardAE == FWD_M ? ALUResultM : e_q.rd1;
  assign fwd_b = ForwardBE == FWD_W ? ResultW : ForwardBE == FWD_M ? ALUResultM : e_q.rd2;
  assign src_b = e_q.ctrl.alu_src ? e_q.imm : fwd_b;
  alu #(.XLEN(XLEN)) u_alu (
    .a_i(src_a), .b_i(src_b), .ctrl_i(e_q.ctrl.alu_control),
    .result_o(ALUResultE), .z_o(z), .n_o(n), .c_o(c), .v_o(v)
  );
  always_comb begin
    cond = 1'b0;
    case (e_q.ctrl.funct3)
      F3_BEQ:  cond = z;
      F3_BNE:  cond = !z;
      F3_BLT:  cond = n ^ v;
      F3_BGE:  cond = !(n ^ v);
      F3_BLTU: cond = !c;
      F3_BGEU: cond = c;
      default: cond = 1'b0;
    endcase
  end
  assign WriteDataE = fwd_b;
  assign PCTargetE  = e_q.pc + e_q.imm;
  assign PCSrcE     = e_q.ctrl.jump | (e_q.ctrl.branch & cond);
  assign PCPlus4E   = e_q.pc4;
  assign RdE        = e_q.rd;
  assign Rs1E       = e_q.rs1;
  assign Rs2E       = e_q.rs2;
  assign RegWriteE  = e_q.ctrl.reg_write;
  assign MemWriteE  = e_q.ctrl.mem_write;
  assign ResultSrcE = e_q.ctrl.result_src;
endmodule
